// File: rtl/acoustics_pkt_pkg.sv
// rtl/acoustics_pkt_pkg.sv - Shared constants, FSM state type and sizing helper for the sample packetizer
package acoustics_pkt_pkg;

   localparam logic [7:0] SYNC0 = 8'hA5;
   localparam logic [7:0] SYNC1 = 8'h5A;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      SEQ,
      SHI,
      SLO,
      CSUM
   } pkt_state_t;

   // Two sync bytes, seq and csum frame the two bytes carried per sample.
   function automatic int pkt_bytes(input int pkt_len);
      return 4 + 2 * pkt_len;
   endfunction

endpackage

// File: rtl/sample_packetizer_if.sv
// rtl/sample_packetizer_if.sv - Sample input, UART byte handshake and status signals of the packetizer
interface sample_packetizer_if #(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 64
);
   logic                    sample_valid;
   logic [SAMPLE_W-1:0]     sample_data;
   logic                    logging_en;
   logic                    tx_ready;
   logic                    tx_send;
   logic [7:0]              tx_byte;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    overflow;
   logic                    busy;

   modport master (
      input  sample_valid, sample_data, logging_en, tx_ready,
      output tx_send, tx_byte, fifo_count, overflow, busy
   );

   modport slave (
      output sample_valid, sample_data, logging_en, tx_ready,
      input  tx_send, tx_byte, fifo_count, overflow, busy
   );

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - Show-ahead synchronous sample FIFO with wrap-bit pointers
module sample_fifo #(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [SAMPLE_W-1:0]    wr_data,
   input  logic                   rd_en,
   output logic [SAMPLE_W-1:0]    head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; occupancy is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sample_packetizer.sv
// rtl/sample_packetizer.sv - Buffers ADC samples and streams them as framed, checksummed UART byte packets
module sample_packetizer #(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 64,
   parameter int PKT_LEN  = 16
) (
   input  logic                clk,
   input  logic                reset,
   sample_packetizer_if.master bus
);
   import acoustics_pkt_pkg::*;

   localparam int               AW         = $clog2(DEPTH);
   localparam int               CNT_W      = $clog2(PKT_LEN + 1);
   localparam logic [AW:0]      PKT_THRESH = (AW+1)'(PKT_LEN);
   localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PKT_LEN);

   pkt_state_t          state, state_n;
   logic                waiting, waiting_n;
   logic                seen_low, seen_low_n;
   logic                tx_send_q, tx_send_n;
   logic [7:0]          tx_byte_q, tx_byte_n;
   logic [7:0]          csum, csum_n;
   logic [7:0]          seq, seq_n;
   logic [CNT_W-1:0]    scnt, scnt_n;
   logic                overflow_q;
   logic                push, pop, drop;
   logic                fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_head;
   logic [AW:0]         fifo_count;
   logic [15:0]         head_ext;
   logic [7:0]          head_hi, head_lo;

   sample_fifo #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data (bus.sample_data),
      .rd_en   (pop),
      .head    (fifo_head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A full FIFO still accepts a sample when the LO byte pops the head this cycle.
   assign push = bus.sample_valid && bus.logging_en && (!fifo_full || pop);
   assign drop = bus.sample_valid && bus.logging_en && fifo_full && !pop;

   assign head_ext = 16'(fifo_head);
   assign head_hi  = head_ext[15:8];
   assign head_lo  = head_ext[7:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         waiting    <= 1'b0;
         seen_low   <= 1'b0;
         tx_send_q  <= 1'b0;
         tx_byte_q  <= 8'h00;
         csum       <= 8'h00;
         seq        <= 8'h00;
         scnt       <= '0;
         overflow_q <= 1'b0;
      end else begin
         state     <= state_n;
         waiting   <= waiting_n;
         seen_low  <= seen_low_n;
         tx_send_q <= tx_send_n;
         tx_byte_q <= tx_byte_n;
         csum      <= csum_n;
         seq       <= seq_n;
         scnt      <= scnt_n;
         if (drop) overflow_q <= 1'b1;
      end
   end

   always_comb begin
      state_n    = state;
      waiting_n  = waiting;
      seen_low_n = seen_low;
      tx_send_n  = 1'b0;
      tx_byte_n  = tx_byte_q;
      csum_n     = csum;
      seq_n      = seq;
      scnt_n     = scnt;
      pop        = 1'b0;

      if (state == IDLE) begin
         scnt_n = '0;
         if (fifo_count >= PKT_THRESH) state_n = HDR0;
      end else if (!waiting) begin
         if (bus.tx_ready) begin
            tx_send_n  = 1'b1;
            waiting_n  = 1'b1;
            seen_low_n = 1'b0;
            case (state)
               HDR0: tx_byte_n = SYNC0;
               HDR1: tx_byte_n = SYNC1;
               SEQ: begin
                  tx_byte_n = seq;
                  csum_n    = seq;
               end
               SHI: begin
                  tx_byte_n = head_hi;
                  csum_n    = csum ^ head_hi;
               end
               SLO: begin
                  tx_byte_n = head_lo;
                  csum_n    = csum ^ head_lo;
                  pop       = !fifo_empty;
                  scnt_n    = scnt + CNT_W'(1);
               end
               CSUM: begin
                  tx_byte_n = csum;
                  seq_n     = seq + 8'd1;
               end
               default: tx_byte_n = tx_byte_q;
            endcase
         end
      end else if (!seen_low) begin
         // The UART must visibly accept the byte before its idle level counts.
         if (!bus.tx_ready) seen_low_n = 1'b1;
      end else if (bus.tx_ready) begin
         waiting_n = 1'b0;
         case (state)
            HDR0:    state_n = HDR1;
            HDR1:    state_n = SEQ;
            SEQ:     state_n = SHI;
            SHI:     state_n = SLO;
            SLO:     state_n = (scnt == PKT_LAST) ? CSUM : SHI;
            CSUM:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.tx_send    = tx_send_q;
   assign bus.tx_byte    = tx_byte_q;
   assign bus.fifo_count = fifo_count;
   assign bus.overflow   = overflow_q;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_sample_packetizer.sv
// tb/tb_sample_packetizer.sv - Scoreboard bench for sample_packetizer with a behavioural UART
module tb_sample_packetizer;
   import acoustics_pkt_pkg::*;

   localparam int SW      = 12;
   localparam int DEPTH   = 64;
   localparam int PKT_LEN = 4;

   logic clk;
   logic reset;

   sample_packetizer_if #(.SAMPLE_W(SW), .DEPTH(DEPTH)) bus ();

   sample_packetizer #(
      .SAMPLE_W (SW),
      .DEPTH    (DEPTH),
      .PKT_LEN  (PKT_LEN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         checks      = 0;
   int         passed      = 0;
   int         nbytes      = 0;
   logic [7:0] exp_q[$];
   logic [11:0] mdl_q[$];
   logic [7:0] mdl_seq     = 8'h00;
   bit         uart_hold   = 1'b0;
   bit         uart_manual = 1'b0;
   int         busy_len    = 10;
   logic       prev_send   = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, %0d bytes outstanding", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
   endtask

   // Reference framing: sync, seq, hi/lo per sample, XOR of seq and sample bytes.
   task automatic model_accept(input logic [11:0] s);
      logic [7:0] c;
      logic [7:0] hi;
      logic [7:0] lo;
      mdl_q.push_back(s);
      if (mdl_q.size() == PKT_LEN) begin
         c = mdl_seq;
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'h5A);
         exp_q.push_back(mdl_seq);
         foreach (mdl_q[k]) begin
            hi = {4'h0, mdl_q[k][11:8]};
            lo = mdl_q[k][7:0];
            c  = c ^ hi ^ lo;
            exp_q.push_back(hi);
            exp_q.push_back(lo);
         end
         exp_q.push_back(c);
         mdl_seq = mdl_seq + 8'd1;
         mdl_q.delete();
      end
   endtask

   // Monitor: every byte strobe is popped against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_send === 1'b1) begin
            check("tx_send_width", {31'b0, prev_send}, 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL tx_unexpected: byte 0x%0h sent, no byte expected", bus.tx_byte);
            end else begin
               check($sformatf("tx_byte[%0d]", nbytes), {24'h0, bus.tx_byte}, {24'h0, exp_q.pop_front()});
            end
            nbytes++;
         end
         prev_send = bus.tx_send;
      end
   end

   // UART: drops tx_ready one cycle after a strobe and stays busy for busy_len cycles.
   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!uart_manual) begin
            if (uart_hold) begin
               bus.tx_ready = 1'b0;
            end else if (bus.tx_send === 1'b1) begin
               @(negedge clk);
               bus.tx_ready = 1'b0;
               repeat (busy_len) @(negedge clk);
               bus.tx_ready = 1'b1;
            end else begin
               bus.tx_ready = 1'b1;
            end
         end
      end
   end

   task automatic push_sample(input logic [11:0] v);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample_data  = v;
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic push_burst(input logic [11:0] base, input int n, input int n_accept);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.sample_valid = 1'b1;
         bus.sample_data  = base + 12'(i);
         if (i < n_accept) model_accept(base + 12'(i));
      end
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < bound) passed++;
      else $display("FAIL idle_timeout: busy=%0b after %0d cycles, expected idle with %0d bytes left", bus.busy, n, exp_q.size());
      repeat (busy_len + 4) @(negedge clk);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      bus.sample_valid = 1'b0;
      exp_q.delete();
      mdl_q.delete();
      mdl_seq = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Manual UART handshake: issue edge, low edge, high edge.
   task automatic step(input bit p, input logic [11:0] v);
      @(negedge clk);
      bus.tx_ready = 1'b1;
      if (p) begin
         bus.sample_valid = 1'b1;
         bus.sample_data  = v;
      end
      @(negedge clk);
      bus.tx_ready     = 1'b0;
      bus.sample_valid = 1'b0;
      @(negedge clk);
      bus.tx_ready = 1'b1;
   endtask

   initial begin
      int         n;
      logic [11:0] v;
      reset            = 1'b1;
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.logging_en   = 1'b0;

      // Reset values and idle behaviour
      repeat (3) @(negedge clk);
      check("rst_tx_send", {31'b0, bus.tx_send}, 32'h0);
      check("rst_tx_byte", {24'h0, bus.tx_byte}, 32'h0);
      check("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
      check("rst_overflow", {31'b0, bus.overflow}, 32'h0);
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      reset = 1'b0;
      bus.logging_en = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_busy", {31'b0, bus.busy}, 32'h0);
      check("idle_fifo_count", 32'(bus.fifo_count), 32'h0);

      // Single hand-computed packet, plus packet-start latency
      busy_len = 10;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
      exp_q.push_back(8'h0A); exp_q.push_back(8'hBC); exp_q.push_back(8'h01);
      exp_q.push_back(8'h23); exp_q.push_back(8'h04); exp_q.push_back(8'h56);
      exp_q.push_back(8'h07); exp_q.push_back(8'h89); exp_q.push_back(8'h48);
      mdl_seq = 8'h01;
      push_sample(12'hABC);
      push_sample(12'h123);
      push_sample(12'h456);
      push_sample(12'h789);
      check("start_count", 32'(bus.fifo_count), 32'd4);
      check("start_busy_n", {31'b0, bus.busy}, 32'h0);
      @(negedge clk);
      check("start_busy_n1", {31'b0, bus.busy}, 32'h1);
      check("start_send_n1", {31'b0, bus.tx_send}, 32'h0);
      @(negedge clk);
      check("start_send_n2", {31'b0, bus.tx_send}, 32'h1);
      wait_idle(1000);
      check("pkt1_busy", {31'b0, bus.busy}, 32'h0);
      check("pkt1_fifo_count", 32'(bus.fifo_count), 32'h0);

      // Overflow: 70 samples into a stalled 64-entry FIFO
      busy_len  = 2;
      uart_hold = 1'b1;
      repeat (3) @(negedge clk);
      push_burst(12'h100, 70, DEPTH);
      repeat (3) @(negedge clk);
      check("ovf_fifo_count", 32'(bus.fifo_count), 32'd64);
      check("ovf_flag", {31'b0, bus.overflow}, 32'h1);
      check("ovf_busy", {31'b0, bus.busy}, 32'h1);
      uart_hold = 1'b0;
      wait_idle(4000);
      check("ovf_drain_count", 32'(bus.fifo_count), 32'h0);
      check("ovf_sticky", {31'b0, bus.overflow}, 32'h1);

      // Gating, then reset in the SHI wait phase
      reset_dut();
      check("ovf_cleared", {31'b0, bus.overflow}, 32'h0);
      busy_len = 10;
      bus.logging_en = 1'b0;
      for (int i = 0; i < 5; i++) push_sample(12'h0F0 + 12'(i));
      repeat (2) @(negedge clk);
      check("gate_fifo_count", 32'(bus.fifo_count), 32'h0);
      check("gate_overflow", {31'b0, bus.overflow}, 32'h0);
      bus.logging_en = 1'b1;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
      exp_q.push_back(8'h00); exp_q.push_back(8'h03);
      push_sample(12'h321);
      push_sample(12'h654);
      push_sample(12'h987);
      push_sample(12'hCBA);
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach_shi", 32'(exp_q.size()), 32'h0);
      @(negedge clk);
      check("mid_busy", {31'b0, bus.busy}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_send", {31'b0, bus.tx_send}, 32'h0);
      check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
      check("mid_rst_count", 32'(bus.fifo_count), 32'h0);
      check("mid_rst_byte", {24'h0, bus.tx_byte}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      mdl_q.delete();
      mdl_seq = 8'h00;
      push_sample(12'h5E1); model_accept(12'h5E1);
      push_sample(12'h0FF); model_accept(12'h0FF);
      push_sample(12'hF00); model_accept(12'hF00);
      push_sample(12'h001); model_accept(12'h001);
      wait_idle(1000);

      // Full FIFO with a push landing on the SLO pop
      @(negedge clk);
      uart_manual  = 1'b1;
      bus.tx_ready = 1'b0;
      push_burst(12'h200, 64, 64);
      repeat (3) @(negedge clk);
      check("full_count", 32'(bus.fifo_count), 32'd64);
      check("full_overflow", {31'b0, bus.overflow}, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 12'h000);
      step(1'b1, 12'hFED);
      model_accept(12'hFED);
      check("pushpop_count", 32'(bus.fifo_count), 32'd64);
      check("pushpop_overflow", {31'b0, bus.overflow}, 32'h0);
      n = 0;
      while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 16 * pkt_bytes(PKT_LEN) + 16) begin
         step(1'b0, 12'h000);
         n++;
      end
      check("pushpop_drained", 32'(exp_q.size()), 32'h0);
      check("pushpop_leftover", 32'(bus.fifo_count), 32'd1);
      uart_manual = 1'b0;
      repeat (4) @(negedge clk);

      // 257 packets: seq runs 00..FF and wraps to 00
      reset_dut();
      busy_len = 2;
      for (int p = 0; p < 257; p++) begin
         for (int i = 0; i < PKT_LEN; i++) begin
            v = 12'((p * 37 + i * 291 + 5) & 32'hFFF);
            push_sample(v);
            model_accept(v);
         end
         n = 0;
         while (exp_q.size() > 2 * pkt_bytes(PKT_LEN) && n < 2000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 2000) begin
            checks++;
            $display("FAIL wrap_throttle: %0d bytes outstanding, expected at most %0d", exp_q.size(), 2 * pkt_bytes(PKT_LEN));
         end
      end
      wait_idle(4000);
      check("wrap_fifo_count", 32'(bus.fifo_count), 32'h0);
      check("wrap_overflow", {31'b0, bus.overflow}, 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
